// File: rtl/hack_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hack_run_ctrl
// Description : Run controller for the Hack CPU. Streams a program into the
//               instruction ROM (valid/ready) while the CPU is held in reset,
//               releases the CPU and counts executed cycles, and stops it when
//               the canonical end loop (@p at p, 0;JMP at p+1) is executed.
// Ports       : clk, reset_n          - clock, synchronous active-low reset
//               load_start/run/stop   - single-cycle requests (stop>load>run)
//               in_valid/in_ready/in_data/in_last - program word stream
//               rom_we/rom_addr/rom_wdata         - ROM write port
//               cpu_reset, cpu_pc, cpu_instruction - CPU control / observation
//               state, halted, prog_len, cycles, err - status
// Revision    : 1.0 - initial release
// ============================================================================
module hack_run_ctrl #(
  parameter int ROM_AW  = 15,
  parameter int CYCLE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_start,
  input  logic                run,
  input  logic                stop,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_data,
  input  logic                in_last,
  output logic                rom_we,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic [15:0]         rom_wdata,
  output logic                cpu_reset,
  input  logic [14:0]         cpu_pc,
  input  logic [15:0]         cpu_instruction,
  output logic [1:0]          state,
  output logic                halted,
  output logic [ROM_AW:0]     prog_len,
  output logic [CYCLE_W-1:0]  cycles,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [ROM_AW:0]    PLEN_ONE  = {{ROM_AW{1'b0}}, 1'b1};
  localparam logic [CYCLE_W-1:0] CYC_ONE   = {{(CYCLE_W-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_W-1:0] CYC_MAX   = {CYCLE_W{1'b1}};

  state_e              state_q, state_d;
  logic [ROM_AW:0]     prog_len_q, prog_len_d;
  logic [CYCLE_W-1:0]  cycles_q, cycles_d;
  logic                err_q, err_d;
  logic [14:0]         prev_pc_q, prev_pc_d;
  logic [15:0]         prev_instr_q, prev_instr_d;
  logic                prev_valid_q, prev_valid_d;

  logic                rom_full;
  logic                accept;
  logic                halt_hit;
  logic [14:0]         prev_pc_inc;

  // prog_len saturates at exactly 2^ROM_AW, so its top bit alone means full.
  assign rom_full    = prog_len_q[ROM_AW];
  assign in_ready    = (state_q == ST_LOAD) && !rom_full;
  assign accept      = in_ready && in_valid;

  assign rom_we      = accept;
  assign rom_addr    = prog_len_q[ROM_AW-1:0];
  assign rom_wdata   = in_data;

  assign cpu_reset   = (state_q != ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign state       = state_q;
  assign prog_len    = prog_len_q;
  assign cycles      = cycles_q;
  assign err         = err_q;

  // End loop: last cycle executed "@p" located at p, this cycle executes an
  // unconditional jump (no destination, jump bits 111) at p+1.
  assign prev_pc_inc = prev_pc_q + 15'd1;
  assign halt_hit    = prev_valid_q
                    && !prev_instr_q[15]
                    && (prev_instr_q[14:0] == prev_pc_q)
                    && (cpu_pc == prev_pc_inc)
                    && cpu_instruction[15]
                    && (cpu_instruction[5:3] == 3'b000)
                    && (cpu_instruction[2:0] == 3'b111);

  always_comb begin
    state_d      = state_q;
    prog_len_d   = prog_len_q;
    cycles_d     = cycles_q;
    err_d        = err_q;
    prev_pc_d    = cpu_pc;
    prev_instr_d = cpu_instruction;
    // History is only meaningful from the second RUN cycle onward.
    prev_valid_d = (state_q == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (load_start) begin
          state_d    = ST_LOAD;
          prog_len_d = '0;
          err_d      = 1'b0;
        end else if (run) begin
          state_d  = ST_RUN;
          cycles_d = '0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          prog_len_d = prog_len_q + PLEN_ONE;
        end
        if (rom_full && in_valid) begin
          err_d = 1'b1;
        end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (accept && in_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + CYC_ONE;
        end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (load_start) begin
          state_d    = ST_LOAD;
          prog_len_d = '0;
          err_d      = 1'b0;
        end else if (halt_hit) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (load_start) begin
          state_d    = ST_LOAD;
          prog_len_d = '0;
          err_d      = 1'b0;
        end else if (run) begin
          state_d  = ST_RUN;
          cycles_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prog_len_q   <= '0;
      cycles_q     <= '0;
      err_q        <= 1'b0;
      prev_pc_q    <= '0;
      prev_instr_q <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      cycles_q     <= cycles_d;
      err_q        <= err_d;
      prev_pc_q    <= prev_pc_d;
      prev_instr_q <= prev_instr_d;
      prev_valid_q <= prev_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_run_ctrl
// Description : Directed self-checking bench for hack_run_ctrl. A default
//               instance (ROM_AW=15) and a small instance (ROM_AW=2) share
//               all inputs; the small one exercises ROM overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_run_ctrl;

  logic        clk;
  logic        reset_n;
  logic        load_start, run, stop;
  logic        in_valid, in_last;
  logic [15:0] in_data;
  logic [14:0] cpu_pc;
  logic [15:0] cpu_instruction;

  logic        in_ready, rom_we, cpu_reset, halted, err;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic [1:0]  state;
  logic [15:0] prog_len;
  logic [31:0] cycles;

  logic        s_in_ready, s_rom_we, s_cpu_reset, s_halted, s_err;
  logic [1:0]  s_rom_addr;
  logic [15:0] s_rom_wdata;
  logic [1:0]  s_state;
  logic [2:0]  s_prog_len;
  logic [31:0] s_cycles;

  int vectors;
  int miscompares;
  logic [15:0] rom_model [0:7];

  hack_run_ctrl dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .run(run), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cpu_instruction(cpu_instruction),
    .state(state), .halted(halted), .prog_len(prog_len), .cycles(cycles), .err(err)
  );

  hack_run_ctrl #(.ROM_AW(2), .CYCLE_W(32)) dut_small (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .run(run), .stop(stop),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .rom_we(s_rom_we), .rom_addr(s_rom_addr), .rom_wdata(s_rom_wdata),
    .cpu_reset(s_cpu_reset), .cpu_pc(cpu_pc), .cpu_instruction(cpu_instruction),
    .state(s_state), .halted(s_halted), .prog_len(s_prog_len), .cycles(s_cycles), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) for the handshake to complete.
  task automatic send_word(input logic [15:0] d, input logic last);
    int waited;
    in_valid = 1'b1; in_data = d; in_last = last;
    waited = 0;
    #1;
    while (!in_ready && waited < 20) begin
      step(); waited++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    #1;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
    vectors++; if (prog_len !== 16'd0) begin miscompares++; $display("FAIL rst_prog_len: got %0d want 0", prog_len); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL rst_cycles: got %0d want 0", cycles); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vectors++; if (rom_we !== 1'b0) begin miscompares++; $display("FAIL rst_rom_we: got %b want 0", rom_we); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_load_backpressure();
    logic [15:0] words [0:5];
    logic        valids [0:5];
    logic        lasts  [0:5];
    int          n_we;
    int          exp_addr;
    words  = '{16'h0002, 16'h0000, 16'hEA87, 16'h0000, 16'h0000, 16'h0001};
    valids = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    lasts  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_start = 1'b1; step(); load_start = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL load_enter_state: got %0d want 1", state); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
    n_we = 0; exp_addr = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = valids[i]; in_data = words[i]; in_last = lasts[i];
      #1;
      vectors++;
      if (rom_we !== valids[i]) begin miscompares++; $display("FAIL load_rom_we[%0d]: got %b want %b", i, rom_we, valids[i]); end
      if (valids[i]) begin
        vectors++;
        if (rom_addr !== exp_addr[14:0] || rom_wdata !== words[i]) begin
          miscompares++;
          $display("FAIL load_write[%0d]: got addr %0d data %h want addr %0d data %h", i, rom_addr, rom_wdata, exp_addr, words[i]);
        end
        rom_model[exp_addr] = words[i];
        exp_addr++;
      end
      if (rom_we === 1'b1) n_we++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    vectors++; if (n_we != 3) begin miscompares++; $display("FAIL load_we_count: got %0d want 3", n_we); end
    vectors++; if (prog_len !== 16'd3) begin miscompares++; $display("FAIL load_prog_len: got %0d want 3", prog_len); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL load_return_idle: got %0d want 0", state); end
  endtask

  task automatic test_halt();
    logic [15:0] prog [0:3];
    prog = '{16'h0002, 16'hEA87, 16'h0002, 16'hEA87};
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rom_model[i] = prog[i];
      send_word(prog[i], (i == 3));
    end
    vectors++; if (prog_len !== 16'd4) begin miscompares++; $display("FAIL halt_prog_len: got %0d want 4", prog_len); end
    cpu_pc = 15'd0; cpu_instruction = rom_model[0];
    run = 1'b1; step(); run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_pc = 15'(i); cpu_instruction = rom_model[i];
      #1;
      vectors++;
      if (state !== 2'd2 || cpu_reset !== 1'b0 || cycles !== 32'(i)) begin
        miscompares++;
        $display("FAIL halt_run_cycle[%0d]: got state %0d cpu_reset %b cycles %0d want 2 0 %0d", i, state, cpu_reset, cycles, i);
      end
      step();
    end
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL halt_state: got %0d want 3", state); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_halted: got %b want 1", halted); end
    vectors++; if (cycles !== 32'd4) begin miscompares++; $display("FAIL halt_cycles: got %0d want 4", cycles); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL halt_cpu_reset: got %b want 1", cpu_reset); end
    step();
    vectors++; if (cycles !== 32'd4 || state !== 2'd3) begin miscompares++; $display("FAIL halt_frozen: got cycles %0d state %0d want 4 3", cycles, state); end
  endtask

  task automatic test_rerun_abort();
    // Park the CPU on "@2" at address 0 so no end loop is seen.
    cpu_pc = 15'd0; cpu_instruction = 16'h0002;
    run = 1'b1; step(); run = 1'b0;
    vectors++; if (state !== 2'd2 || cycles !== 32'd0) begin miscompares++; $display("FAIL rerun_restart: got state %0d cycles %0d want 2 0", state, cycles); end
    step(); step(); step();
    vectors++; if (cycles !== 32'd3) begin miscompares++; $display("FAIL rerun_count: got %0d want 3", cycles); end
    stop = 1'b1; step(); stop = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL abort_state: got %0d want 0", state); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL abort_cpu_reset: got %b want 1", cpu_reset); end
    vectors++; if (cycles !== 32'd4) begin miscompares++; $display("FAIL abort_cycles: got %0d want 4", cycles); end
    step(); step();
    vectors++; if (cycles !== 32'd4) begin miscompares++; $display("FAIL abort_frozen: got %0d want 4", cycles); end
  endtask

  task automatic test_simultaneous();
    load_start = 1'b1; run = 1'b1; step(); load_start = 1'b0; run = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL simul_load_over_run: got %0d want 1", state); end
    vectors++; if (prog_len !== 16'd0) begin miscompares++; $display("FAIL simul_prog_len_clear: got %0d want 0", prog_len); end
    stop = 1'b1; step(); stop = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL simul_stop_load: got %0d want 0", state); end
    run = 1'b1; step(); run = 1'b0;
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL simul_run: got %0d want 2", state); end
    stop = 1'b1; load_start = 1'b1; step(); stop = 1'b0; load_start = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL simul_stop_over_load: got %0d want 0", state); end
  endtask

  task automatic test_overflow();
    load_start = 1'b1; step(); load_start = 1'b0;
    vectors++; if (s_state !== 2'd1 || s_err !== 1'b0) begin miscompares++; $display("FAIL ovf_enter: got state %0d err %b want 1 0", s_state, s_err); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h1000 + 16'(i); in_last = 1'b0;
      #1;
      vectors++;
      if (s_rom_we !== (i < 4) || s_in_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL ovf_offer[%0d]: got we %b ready %b want %b %b", i, s_rom_we, s_in_ready, (i < 4), (i < 4));
      end
      if (i < 4) begin
        vectors++;
        if (s_rom_addr !== 2'(i)) begin miscompares++; $display("FAIL ovf_addr[%0d]: got %0d want %0d", i, s_rom_addr, i); end
      end
      if (i == 4) begin
        vectors++;
        if (s_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_early: got %b want 0", s_err); end
      end
      step();
    end
    in_valid = 1'b0;
    vectors++; if (s_err !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", s_err); end
    vectors++; if (s_prog_len !== 3'd4) begin miscompares++; $display("FAIL ovf_prog_len: got %0d want 4", s_prog_len); end
    vectors++; if (s_state !== 2'd1) begin miscompares++; $display("FAIL ovf_stay_load: got %0d want 1", s_state); end
    step(); step();
    vectors++; if (s_state !== 2'd1 || s_in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_hold: got state %0d ready %b want 1 0", s_state, s_in_ready); end
    stop = 1'b1; step(); stop = 1'b0;
    vectors++; if (s_state !== 2'd0 || s_err !== 1'b1) begin miscompares++; $display("FAIL ovf_stop: got state %0d err %b want 0 1", s_state, s_err); end
    // Large instance accepted all five words without overflowing.
    vectors++; if (prog_len !== 16'd5 || err !== 1'b0) begin miscompares++; $display("FAIL ovf_big_dut: got len %0d err %b want 5 0", prog_len, err); end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; step(); load_start = 1'b0;
    send_word(16'h0011, 1'b0);
    send_word(16'h0022, 1'b0);
    vectors++; if (prog_len !== 16'd2 || state !== 2'd1) begin miscompares++; $display("FAIL rmid_pre: got len %0d state %0d want 2 1", prog_len, state); end
    reset_n = 1'b0; in_valid = 1'b1; in_data = 16'h0033;
    step();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rmid_state: got %0d want 0", state); end
    vectors++; if (prog_len !== 16'd0) begin miscompares++; $display("FAIL rmid_prog_len: got %0d want 0", prog_len); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    vectors++; if (rom_we !== 1'b0) begin miscompares++; $display("FAIL rmid_rom_we: got %b want 0", rom_we); end
    reset_n = 1'b1; in_valid = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; load_start = 1'b0; run = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
    cpu_pc = 15'd0; cpu_instruction = 16'h0000;
    for (int i = 0; i < 8; i++) rom_model[i] = 16'h0000;
    test_reset();
    test_load_backpressure();
    test_halt();
    test_rerun_abort();
    test_simultaneous();
    test_reset();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_run_ctrl.md
# hack_run_ctrl

Run controller for the Hack CPU. It loads a program into instruction ROM from a valid/ready word stream while the CPU is held in reset. It then releases the CPU and counts executed cycles. It stops the CPU when the program reaches the canonical Hack end loop (`@p` at address p, `0;JMP` at p+1). It sits between the host/test harness, the instruction ROM write port and the CPU's `reset` input.

## Interface
- `ROM_AW`, default 15: instruction ROM address width; capacity 2^ROM_AW words.
- `CYCLE_W`, default 32: width of the cycle counter.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `load_start` in 1: single-cycle request to enter LOAD.
- `run` in 1: single-cycle request to enter RUN.
- `stop` in 1: single-cycle request to abort to IDLE.
- `in_valid` in 1: a program word is offered.
- `in_ready` out 1: the controller accepts the offered word.
- `in_data` in 16: program word.
- `in_last` in 1: marks the offered word as the final one.
- `rom_we` out 1: ROM write strobe.
- `rom_addr` out ROM_AW: ROM write address.
- `rom_wdata` out 16: ROM write data.
- `cpu_reset` out 1: active-high reset to the CPU.
- `cpu_pc` in 15: CPU `pc`.
- `cpu_instruction` in 16: instruction currently fetched from ROM[pc].
- `state` out 2: IDLE=0, LOAD=1, RUN=2, HALT=3.
- `halted` out 1: high while in HALT.
- `prog_len` out ROM_AW+1: number of words loaded.
- `cycles` out CYCLE_W: RUN cycle count, saturating.
- `err` out 1: sticky flag, set when a word is offered while the ROM is full.

## Operation
- Reset (`reset_n`=0 at an edge): state is IDLE, `prog_len`=0, `cycles`=0, `err`=0. Outputs during reset: `in_ready`=0, `rom_we`=0, `cpu_reset`=1, `halted`=0. Reset overrides everything, including mid-LOAD and mid-RUN.
- Request priority when several are high in one cycle: `stop` > `load_start` > `run`. A request that does not apply in the current state is ignored.
- IDLE:
  - `load_start` → LOAD; `prog_len` and `err` are cleared.
  - `run` → RUN; `cycles` is cleared.
- LOAD:
  - `in_ready` = (`prog_len` < 2^ROM_AW).
  - A word is accepted when `in_valid` and `in_ready` are both high. In that cycle, combinationally: `rom_we`=1, `rom_addr`=`prog_len`[ROM_AW-1:0], `rom_wdata`=`in_data`. `prog_len` increments at the edge.
  - An accepted word with `in_last`=1 → IDLE.
  - When full, `in_ready`=0. If `in_valid`=1 while full, `err` is set and the word is dropped. The controller stays in LOAD until `stop`.
  - `stop` → IDLE; words already written are kept.
- RUN:
  - `cpu_reset`=0.
  - `cycles` increments every RUN cycle, saturating at all-ones.
  - `stop` → IDLE.
  - `load_start` → LOAD; this clears `prog_len` and `err`.
- Halt detection:
  - Registered previous-cycle copies `prev_pc` and `prev_instr`, plus `prev_valid`. `prev_valid`=0 on the first RUN cycle and 1 afterwards.
  - HALT is the next state when all of the following hold:
    - `prev_valid`.
    - `prev_instr[15]`=0 and `prev_instr[14:0]`==`prev_pc`.
    - `cpu_pc`==`prev_pc`+1 (mod 2^15).
    - `cpu_instruction[15]`=1, `[5:3]`=000 and `[2:0]`=111.
- HALT:
  - `cpu_reset`=1, `halted`=1; `cycles` is frozen.
  - `run` → RUN with `cycles` cleared.
  - `load_start` → LOAD.
  - `stop` → IDLE.
- `cpu_reset` = (state != RUN), decoded from the state register.

## Timing
- All transitions take effect at the edge after the request is sampled. There is no combinational path from a request input to `state`.
- `run` sampled at edge t:
  - State is RUN from t+1; `cpu_reset` is low from t+1.
  - The CPU PC, held at 0 by the earlier reset, executes ROM[0] during cycle t+1.
  - `cycles` is 0 during t+1, 1 during t+2, and so on.
- Halt: the detection condition is true in the cycle executing `0;JMP`. State is HALT the next cycle, and `cpu_reset` rises in that same cycle. `cycles` then holds the number of RUN cycles, including the jump cycle.
- Write timing: `rom_we` is asserted in the same cycle the word is accepted; the ROM captures it at that edge. `prog_len` shows the new count one cycle later.
- `in_ready` is a function of state and `prog_len` only; it never depends on `in_valid`.

## Test plan
- Load handshake with back-pressure: `load_start`, then words 0x0002, 0xEA87, 0x0001 with `in_valid` gaps and `in_last` on the third word → `rom_we` exactly 3 times at addresses 0, 1, 2; `prog_len`=3; state returns to IDLE.
- End-loop halt: load `@2`, `0;JMP`, `@2`, `0;JMP` (0x0002, 0xEA87, 0x0002, 0xEA87), then `run` → PC sequence 0, 1, 2, 3; HALT the cycle after PC=3; `halted`=1; `cycles`=4; `cpu_reset`=1.
- Rerun and abort: `run` from HALT → `cycles` restarts at 0. On another run, `stop` asserted mid-run → IDLE next cycle, `cpu_reset`=1, `cycles` frozen.
- Overflow with `ROM_AW`=2: offer 5 words without `in_last` → 4 writes; `in_ready` low after the 4th; `err`=1 after the 5th offer; state stays LOAD until `stop`.
- Simultaneous requests: `load_start`=`run`=1 in IDLE → LOAD. `stop`=`load_start`=1 in RUN → IDLE.
- Reset mid-operation: `reset_n`=0 during LOAD after 2 words → next cycle IDLE, `prog_len`=0, `in_ready`=0, `rom_we`=0.
